nec_ir_tx: RTL and testbench
============================

Name: nec_ir_tx

Overview:
NEC-format infrared transmitter. It serialises a 16-bit address and a 16-bit data word into a standard NEC frame: 9 ms leader mark, 4.5 ms space, 32 pulse-distance bits sent LSB first, then a stop burst. It can also send an NEC repeat code. It produces an active-low demodulated envelope that loops straight back into the HT6221 receiver, plus a 38 kHz modulated LED drive. It sits next to the receiver on the 50 MHz board clock.

Parameters:
T_LEAD_MARK, 450000, leader mark length in clk cycles (9 ms)
T_LEAD_SPACE, 225000, leader space length for a data frame (4.5 ms)
T_REP_SPACE, 112500, leader space length for a repeat code (2.25 ms)
T_BIT_MARK, 28000, mark length of every bit and of the stop burst (0.56 ms)
T_ZERO_SPACE, 28000, space length after the mark for a logic 0 (0.56 ms)
T_ONE_SPACE, 84500, space length after the mark for a logic 1 (1.69 ms)
T_GAP, 2000000, minimum idle time after the stop burst before the next start is accepted (40 ms)
CARRIER_DIV, 1316, carrier period in clk cycles (about 38 kHz)
CARRIER_EN, 1, 1 = ir_led is modulated; 0 = ir_led is the plain envelope

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous reset, active low
start  in  1  single-cycle request to send; accepted only in IDLE
repeat  in  1  sampled together with start; 1 = send a repeat code instead of a data frame
addr  in  16  address field; sampled when start is accepted
data  in  16  data field; sampled when start is accepted
ir_env  out  1  envelope: 1 = idle/space, 0 = mark (same polarity as the receiver's iIR)
ir_led  out  1  LED drive: 1 = LED on
busy  out  1  high while a transmission or its gap is in progress
done  out  1  one-cycle pulse when the gap ends

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, ir_env=1, ir_led=0, busy=0, done=0; all counters, the shift register and bit_cnt are 0. Asserting rst_n mid-frame aborts the frame at once, with no stop burst.
- All outputs are registered.
- States and their durations (phase counter starts at 0 on entry; each state lasts exactly its parameter in cycles):
  - IDLE -> LEAD_MARK when start=1. On that edge: latch {data, addr} into a 32-bit shift register (addr in bits 15:0), latch repeat, set busy=1, set ir_env=0.
  - LEAD_MARK (T_LEAD_MARK, ir_env=0) -> LEAD_SPACE.
  - LEAD_SPACE (ir_env=1) lasts T_LEAD_SPACE for a data frame or T_REP_SPACE for a repeat code.
    - Data frame: -> BIT_MARK.
    - Repeat code: -> STOP_MARK.
  - BIT_MARK (T_BIT_MARK, ir_env=0) -> BIT_SPACE.
  - BIT_SPACE (ir_env=1) lasts T_ONE_SPACE if the current bit (sreg[0]) is 1, else T_ZERO_SPACE.
    - At its end: shift the register right by 1 and increment bit_cnt.
    - bit_cnt reaching 32 -> STOP_MARK; otherwise -> BIT_MARK.
  - STOP_MARK (T_BIT_MARK, ir_env=0) -> GAP.
  - GAP (T_GAP, ir_env=1) -> IDLE. On that edge: busy=0 and done=1 for one cycle.
- Bit order on the line: addr[0] first through addr[15], then data[0] through data[15]. The HT6221 receiver therefore recovers iraddr=addr and irdata=data.
- start while busy=1 is ignored; nothing is queued. start on the same edge that done pulses is ignored. start one cycle after done is accepted.
- addr, data and repeat may change freely after the start edge.
- Carrier (CARRIER_EN=1):
  - carrier counter counts 0..CARRIER_DIV-1 and wraps.
  - It is forced to 0 on every transition into a mark state, so every mark begins with LED on.
  - During a mark, ir_led=1 while count < CARRIER_DIV/2 (integer divide), else 0.
  - In every non-mark state ir_led=0.
- CARRIER_EN=0: ir_led = ~ir_env.
- Total frame length for addr=0, data=0:
  - leader: 450000 + 225000
  - bits: 32 × (28000 + 28000)
  - stop burst: 28000
  - gap: T_GAP
  - Each all-ones field adds 56500 × 16.

Test Plan:
1. Reset: hold rst_n=0 with start pulsing -> ir_env=1, ir_led=0, busy=0, done=0 throughout.
2. Frame addr=0x00FF, data=0xA25D, default params -> ir_env low for exactly 450000 cycles, then high for 225000; the first 8 bit spaces are 84500 cycles and the next 8 are 28000; there are exactly 33 low pulses after the leader, each 28000 cycles; done pulses once, T_GAP cycles after the stop burst ends.
3. Loopback: ir_env drives the HT6221 iIR, same clk/rst_n -> get_flag pulses, iraddr=0x00FF, irdata=0xA25D; a second frame with addr=0x1234, data=0xFFFF -> iraddr=0x1234, irdata=0xFFFF.
4. Repeat: start with repeat=1 -> 450000 low, 112500 high, 28000 low, then the gap; exactly 2 low pulses; done pulses once.
5. Collision: start pulses mid-frame and on the done cycle -> both ignored and the waveform is unchanged; start one cycle after done -> a new leader begins on the next edge.
6. Carrier: count ir_led rising edges inside the leader -> ceil(450000/1316) = 342; ir_led high 658 cycles and low 658 cycles per period; ir_led=0 in every space; mid-frame rst_n drop -> ir_env=1 and ir_led=0 immediately, and busy=0.

Source files
------------

// File: rtl/nec_ir_tx.sv
// NEC infrared transmitter: leader, 32 pulse-distance bits (LSB first), stop burst and idle gap, or a repeat code.
// Registered outputs; ir_env is an active-low envelope and ir_led the optionally 38 kHz-modulated LED drive.
module nec_ir_tx #(
   parameter int T_LEAD_MARK  = 450000,
   parameter int T_LEAD_SPACE = 225000,
   parameter int T_REP_SPACE  = 112500,
   parameter int T_BIT_MARK   = 28000,
   parameter int T_ZERO_SPACE = 28000,
   parameter int T_ONE_SPACE  = 84500,
   parameter int T_GAP        = 2000000,
   parameter int CARRIER_DIV  = 1316,
   parameter int CARRIER_EN   = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        repeat_code,
   input  logic [15:0] addr,
   input  logic [15:0] data,
   output logic        ir_env,
   output logic        ir_led,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] ph_cnt, ph_len;
   logic [31:0] sreg;
   logic [5:0]  bit_cnt;
   logic        rep;
   logic [31:0] car_cnt, car_nxt;
   logic        ph_end, mark_nxt, enter_mark, led_nxt;

   always_comb begin
      ph_len = 32'd1;
      case (state)
         LEAD_MARK:           ph_len = 32'(T_LEAD_MARK);
         LEAD_SPACE:          ph_len = rep ? 32'(T_REP_SPACE) : 32'(T_LEAD_SPACE);
         BIT_MARK, STOP_MARK: ph_len = 32'(T_BIT_MARK);
         BIT_SPACE:           ph_len = sreg[0] ? 32'(T_ONE_SPACE) : 32'(T_ZERO_SPACE);
         GAP:                 ph_len = 32'(T_GAP);
         default:             ph_len = 32'd1;
      endcase
   end

   assign ph_end = (ph_cnt == ph_len - 32'd1);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:       if (start) state_nxt = LEAD_MARK;
         LEAD_MARK:  if (ph_end) state_nxt = LEAD_SPACE;
         LEAD_SPACE: if (ph_end) state_nxt = rep ? STOP_MARK : BIT_MARK;
         BIT_MARK:   if (ph_end) state_nxt = BIT_SPACE;
         // bit_cnt increments on this same edge, so 31 here means the 32nd bit just finished
         BIT_SPACE:  if (ph_end) state_nxt = (bit_cnt == 6'd31) ? STOP_MARK : BIT_MARK;
         STOP_MARK:  if (ph_end) state_nxt = GAP;
         GAP:        if (ph_end) state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
   end

   assign mark_nxt   = (state_nxt == LEAD_MARK) || (state_nxt == BIT_MARK) || (state_nxt == STOP_MARK);
   assign enter_mark = mark_nxt && (state_nxt != state);

   // Restarting the carrier on each mark entry makes every burst open with the LED on.
   always_comb begin
      car_nxt = car_cnt + 32'd1;
      if (enter_mark || (car_cnt == 32'(CARRIER_DIV - 1)))
         car_nxt = 32'd0;
      led_nxt = mark_nxt;
      if (CARRIER_EN != 0)
         led_nxt = mark_nxt && (car_nxt < 32'(CARRIER_DIV / 2));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         ph_cnt  <= 32'd0;
         sreg    <= 32'd0;
         bit_cnt <= 6'd0;
         rep     <= 1'b0;
         car_cnt <= 32'd0;
         ir_env  <= 1'b1;
         ir_led  <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_nxt;
         ph_cnt  <= (state_nxt != state || state == IDLE) ? 32'd0 : ph_cnt + 32'd1;
         car_cnt <= car_nxt;
         ir_env  <= !mark_nxt;
         ir_led  <= led_nxt;
         busy    <= (state_nxt != IDLE);
         done    <= (state == GAP) && ph_end;
         if (state == IDLE && start) begin
            sreg    <= {data, addr};
            rep     <= repeat_code;
            bit_cnt <= 6'd0;
         end else if (state == BIT_SPACE && ph_end) begin
            sreg    <= sreg >> 1;
            bit_cnt <= bit_cnt + 6'd1;
         end
      end
   end

endmodule

// File: tb/tb_nec_ir_tx.sv
// Directed bench for nec_ir_tx with shortened timings: envelope segment lengths, decoded bits, repeat, collisions, carrier, reset.
module tb_nec_ir_tx;
   localparam int LM = 90, LS = 45, RS = 23, BM = 6, ZS = 6, OS = 17, GP = 40, DIV = 20;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        repeat_code = 1'b0;
   logic [15:0] addr = 16'h0, data = 16'h0;
   logic        ir_env, ir_led, busy, done;

   int tests = 0, fails = 0;
   int seg[$];
   int exp_seg[$];
   int led_rises, led_hi, led_in_space;
   int s_mid, s_last;

   nec_ir_tx #(
      .T_LEAD_MARK(LM), .T_LEAD_SPACE(LS), .T_REP_SPACE(RS), .T_BIT_MARK(BM),
      .T_ZERO_SPACE(ZS), .T_ONE_SPACE(OS), .T_GAP(GP), .CARRIER_DIV(DIV), .CARRIER_EN(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .repeat_code(repeat_code),
      .addr(addr), .data(data), .ir_env(ir_env), .ir_led(ir_led), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic void build_exp(input logic [15:0] a, input logic [15:0] d, input logic r);
      logic [31:0] w;
      w = {d, a};
      exp_seg.delete();
      exp_seg.push_back(LM);
      exp_seg.push_back(r ? RS : LS);
      if (!r)
         for (int i = 0; i < 32; i++) begin
            exp_seg.push_back(BM);
            exp_seg.push_back(w[i] ? OS : ZS);
         end
      exp_seg.push_back(BM);
      exp_seg.push_back(GP);
   endfunction

   // Launches a frame and records ir_env run lengths until done; start may be re-pulsed at samples s_mid/s_last.
   task automatic send(input logic [15:0] a, input logic [15:0] d, input logic r, output int ok);
      int run, n;
      logic prev, prevled;
      addr = a; data = d; repeat_code = r; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; addr = 16'hDEAD; data = 16'hBEEF; repeat_code = ~r;
      seg.delete();
      run = 0; prev = 1'b0; prevled = 1'b0; n = 0; ok = 0;
      led_rises = 0; led_hi = 0; led_in_space = 0;
      while (n < 5000) begin
         if (done) begin
            seg.push_back(run);
            ok = 1;
            start = (n == s_last + 1);
            break;
         end
         if (ir_env == prev) run++;
         else begin seg.push_back(run); run = 1; prev = ir_env; end
         if (ir_env && ir_led) led_in_space++;
         if (seg.size() == 0 && ir_led) begin
            led_hi++;
            if (!prevled) led_rises++;
         end
         prevled = ir_led;
         start = (n == s_mid) || (n == s_last);
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic check_frame(input string tag, input logic [15:0] a, input logic [15:0] d, input logic r);
      logic [31:0] w;
      int bits;
      chk({tag, " nseg"}, seg.size(), exp_seg.size());
      for (int i = 0; i < exp_seg.size() && i < seg.size(); i++)
         chk($sformatf("%s seg%0d", tag, i), seg[i], exp_seg[i]);
      if (!r && seg.size() >= 68) begin
         w = 32'd0;
         for (int i = 0; i < 32; i++) w[i] = (seg[3 + 2 * i] > (OS + ZS) / 2);
         chk({tag, " rx_addr"}, int'(w[15:0]), int'(a));
         chk({tag, " rx_data"}, int'(w[31:16]), int'(d));
      end
      bits = (seg.size() - 2) / 2;
      chk({tag, " low_pulses_after_lead"}, bits, r ? 1 : 33);
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!done && n < 5000) begin @(posedge clk); #1; n++; end
      chk({tag, " done_seen"}, int'(done), 1);
   endtask

   initial begin
      int ok, total;
      s_mid = -10; s_last = -10;
      // 1: reset held with start pulsing
      for (int i = 0; i < 6; i++) begin
         start = i[0];
         @(posedge clk); #1;
         chk("rst env", int'(ir_env), 1);
         chk("rst led", int'(ir_led), 0);
         chk("rst busy", int'(busy), 0);
         chk("rst done", int'(done), 0);
      end
      start = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 2/3/6: data frame, loopback decode, carrier inside the leader
      build_exp(16'h00FF, 16'hA25D, 1'b0);
      send(16'h00FF, 16'hA25D, 1'b0, ok);
      chk("f1 done_seen", ok, 1);
      check_frame("f1", 16'h00FF, 16'hA25D, 1'b0);
      chk("f1 busy_at_done", int'(busy), 0);
      chk("lead led_rises", led_rises, (LM + DIV - 1) / DIV);
      chk("lead led_hi", led_hi, 4 * (DIV / 2) + DIV / 2);
      chk("space led_on", led_in_space, 0);
      @(posedge clk); #1;
      chk("f1 done_one_cycle", int'(done), 0);
      @(posedge clk); #1;

      // 5: collisions mid-frame and on the done edge, then an accepted start right after done
      build_exp(16'h1234, 16'hFFFF, 1'b0);
      total = 0;
      foreach (exp_seg[i]) total += exp_seg[i];
      s_mid = 200; s_last = total - 1;
      send(16'h1234, 16'hFFFF, 1'b0, ok);
      chk("f2 done_seen", ok, 1);
      check_frame("f2", 16'h1234, 16'hFFFF, 1'b0);
      @(posedge clk); #1;
      start = 1'b0;
      s_mid = -10; s_last = -10;
      chk("chain env_low", int'(ir_env), 0);
      chk("chain busy", int'(busy), 1);
      wait_done("chain");
      @(posedge clk); #1;
      @(posedge clk); #1;

      // 4: repeat code
      build_exp(16'h0, 16'h0, 1'b1);
      send(16'h5555, 16'hAAAA, 1'b1, ok);
      chk("rep done_seen", ok, 1);
      check_frame("rep", 16'h0, 16'h0, 1'b1);
      @(posedge clk); #1;

      // 6: asynchronous reset during a leader burst
      addr = 16'h0; data = 16'h0; repeat_code = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      chk("pre_rst led", int'(ir_led), 1);
      chk("pre_rst env", int'(ir_env), 0);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst env", int'(ir_env), 1);
      chk("midrst led", int'(ir_led), 0);
      chk("midrst busy", int'(busy), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      chk("post_rst env", int'(ir_env), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
